// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer datapath: sequencer state
// encoding, index-width helper and default sizes.
package nn_pkg;

  localparam int unsigned NUM_NEURONS_DEFAULT = 10;
  localparam int unsigned DATA_W_DEFAULT      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRE  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_result_buffer.sv
// Per-layer result store: one synchronous write port, one asynchronous read
// port, whole array cleared by reset.
module layer_result_buffer
  import nn_pkg::*;
#(
  parameter int unsigned DEPTH = NUM_NEURONS_DEFAULT,
  parameter int unsigned WIDTH = DATA_W_DEFAULT,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/layer_sequencer.sv
// Layer controller: fires the neuron controller once per neuron index, buffers
// each result, then streams the buffered results to the next layer in order.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEFAULT,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                neuron_start,
  input  logic                                neuron_ready,
  input  logic [DATA_W-1:0]                   neuron_out,
  output logic [idx_width(NUM_NEURONS)-1:0]   neuron_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W-1:0]                   out_data,
  output logic [idx_width(NUM_NEURONS)-1:0]   out_idx,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned      IDX_W    = idx_width(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  seq_state_t        state;
  logic              capture;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rd_val;

  assign capture = (state == ST_WAIT) && neuron_ready;

  // Read address is the beat that will be presented after the next transfer.
  always_comb begin
    rd_idx = '0;
    if ((state == ST_DRAIN) && (out_idx != LAST_IDX)) begin
      rd_idx = out_idx + IDX_W'(1);
    end
  end

  // Forward a result being written this cycle (single-neuron layer case).
  assign rd_val = (capture && (neuron_idx == rd_idx)) ? neuron_out : rd_data;

  layer_result_buffer #(
    .DEPTH (NUM_NEURONS),
    .WIDTH (DATA_W),
    .AW    (IDX_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_idx  (neuron_idx),
    .wr_data (neuron_out),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      neuron_idx   <= '0;
      out_idx      <= '0;
      neuron_start <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      neuron_start <= 1'b0;
      done         <= 1'b0;
      case (state)
        ST_IDLE: begin
          neuron_idx <= '0;
          out_idx    <= '0;
          if (start) begin
            state        <= ST_FIRE;
            neuron_start <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_FIRE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (neuron_ready) begin
            if (neuron_idx == LAST_IDX) begin
              state     <= ST_DRAIN;
              out_idx   <= '0;
              out_valid <= 1'b1;
              out_data  <= rd_val;
            end else begin
              neuron_idx   <= neuron_idx + IDX_W'(1);
              state        <= ST_FIRE;
              neuron_start <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= out_idx + IDX_W'(1);
              out_data <= rd_val;
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          neuron_idx <= '0;
          out_idx    <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a 3-neuron instance driven by a
// fixed-latency neuron model, plus a 1-neuron instance for the degenerate pass.
module tb_layer_sequencer;

  localparam int unsigned N   = 3;
  localparam int unsigned LAT = 9;

  logic       clk = 1'b0;
  logic       rst;

  logic       start_a, nstart_a, nready_a, oval_a, ordy_a, busy_a, done_a;
  logic [7:0] nout_a, odata_a;
  logic [1:0] nidx_a, oidx_a;

  logic       start_b, nstart_b, nready_b, oval_b, ordy_b, busy_b, done_b;
  logic [7:0] nout_b, odata_b;
  logic [0:0] nidx_b, oidx_b;

  always #5 clk = ~clk;

  layer_sequencer #(.NUM_NEURONS(N), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .neuron_start(nstart_a),
    .neuron_ready(nready_a), .neuron_out(nout_a), .neuron_idx(nidx_a),
    .out_valid(oval_a), .out_ready(ordy_a), .out_data(odata_a),
    .out_idx(oidx_a), .busy(busy_a), .done(done_a)
  );

  layer_sequencer #(.NUM_NEURONS(1), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .neuron_start(nstart_b),
    .neuron_ready(nready_b), .neuron_out(nout_b), .neuron_idx(nidx_b),
    .out_valid(oval_b), .out_ready(ordy_b), .out_data(odata_b),
    .out_idx(oidx_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int unsigned idx;
    logic [7:0]  data;
  } beat_t;

  beat_t      q[$];
  logic [7:0] vals [N] = '{8'h11, 8'h22, 8'h33};

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  cnt = 0;
  int  k = 0;
  int  fire_k = 0;
  int  fires = 0;
  int  stall_left = 0;
  int  first_cyc = 0;
  int  done_cyc = 0;
  bit  done_exp = 1'b0;
  bit  done_seen = 1'b0;
  bit  spur = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock of the neuron model, spurious-ready injector and output scoreboard.
  task automatic step();
    beat_t b;
    @(posedge clk);
    #1;
    cyc++;
    check_eq("done", 32'(done_a), 32'(done_exp));
    if (done_a) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    nready_a = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        nready_a = 1'b1;
        nout_a   = vals[k % N];
        b.idx    = 32'(k);
        b.data   = vals[k % N];
        q.push_back(b);
        k++;
      end
    end
    if (nstart_a) begin
      fires++;
      check_eq("fire_idx", 32'(nidx_a), 32'(fire_k));
      fire_k++;
      cnt = LAT;
    end
    if (spur && !nready_a && (!busy_a || nstart_a)) begin
      nready_a = 1'b1;
      nout_a   = 8'hEE;
    end
    done_exp = 1'b0;
    ordy_a   = 1'b1;
    if (oval_a) begin
      if (q.size() == 0) begin
        check_eq("beat_without_result", 32'(oval_a), 32'd0);
      end else begin
        if (stall_left > 0 && q[0].idx == 1) begin
          ordy_a = 1'b0;
          stall_left--;
        end
        check_eq("out_data", 32'(odata_a), 32'(q[0].data));
        check_eq("out_idx", 32'(oidx_a), q[0].idx);
        if (ordy_a) begin
          b = q.pop_front();
          if (b.idx == 0) first_cyc = cyc;
          done_exp = (b.idx == N - 1);
        end
      end
    end
  endtask

  task automatic pass_a(input int stall, input bit start_on_done, input bit restart_busy);
    k = 0; fire_k = 0; fires = 0; done_seen = 1'b0;
    stall_left = stall; first_cyc = 0; done_cyc = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_eq("first_fire", 32'(nstart_a), 32'd1);
    for (int t = 0; t < 300 && !done_seen; t++) begin
      start_a = (restart_busy && t >= 15 && t < 20);
      step();
    end
    start_a = 1'b0;
    check_eq("pass_done", 32'(done_seen), 32'd1);
    check_eq("fires", 32'(fires), 32'(N));
    check_eq("drain_len", 32'(done_cyc - first_cyc), 32'(N + stall));
    check_eq("busy_in_done", 32'(busy_a), 32'd1);
    if (start_on_done) begin
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      check_eq("start_in_done_ignored", 32'(busy_a), 32'd0);
    end else begin
      step();
    end
    check_eq("idle_busy", 32'(busy_a), 32'd0);
    check_eq("idle_nidx", 32'(nidx_a), 32'd0);
    check_eq("idle_oidx", 32'(oidx_a), 32'd0);
    check_eq("q_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_nstart"}, 32'(nstart_a), 32'd0);
    check_eq({tag, "_oval"},   32'(oval_a),   32'd0);
    check_eq({tag, "_busy"},   32'(busy_a),   32'd0);
    check_eq({tag, "_done"},   32'(done_a),   32'd0);
    check_eq({tag, "_nidx"},   32'(nidx_a),   32'd0);
    check_eq({tag, "_oidx"},   32'(oidx_a),   32'd0);
    check_eq({tag, "_odata"},  32'(odata_a),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; nready_a = 1'b0; nout_a = '0; ordy_a = 1'b1;
    start_b = 1'b0; nready_b = 1'b0; nout_b = '0; ordy_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check_eq("reset_b_busy", 32'(busy_b), 32'd0);
    rst = 1'b0;
    step();

    // Plain pass, then backpressure on beat 1 with start in the DONE cycle.
    pass_a(0, 1'b0, 1'b0);
    pass_a(4, 1'b1, 1'b0);

    // Spurious ready in IDLE/FIRE and start re-asserted while busy.
    spur = 1'b1;
    step();
    step();
    pass_a(0, 1'b0, 1'b1);
    spur = 1'b0;

    // Abort a pass while waiting on neuron 1.
    k = 0; fire_k = 0; fires = 0; done_seen = 1'b0; stall_left = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int t = 0; t < 100 && fire_k < 2; t++) step();
    step();
    step();
    check_eq("pre_rst_nidx", 32'(nidx_a), 32'd1);
    check_eq("pre_rst_busy", 32'(busy_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("rst_next");
    cnt = 0; q.delete(); nready_a = 1'b0; done_exp = 1'b0;
    step();
    pass_a(0, 1'b0, 1'b0);

    // Single-neuron layer.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check_eq("b_fire", 32'(nstart_b), 32'd1);
    check_eq("b_nidx", 32'(nidx_b), 32'd0);
    check_eq("b_busy", 32'(busy_b), 32'd1);
    step();
    check_eq("b_fire_once", 32'(nstart_b), 32'd0);
    step();
    nready_b = 1'b1;
    nout_b   = 8'hFF;
    step();
    nready_b = 1'b0;
    check_eq("b_oval", 32'(oval_b), 32'd1);
    check_eq("b_odata", 32'(odata_b), 32'hFF);
    check_eq("b_oidx", 32'(oidx_b), 32'd0);
    step();
    check_eq("b_done", 32'(done_b), 32'd1);
    check_eq("b_oval_off", 32'(oval_b), 32'd0);
    step();
    check_eq("b_done_pulse", 32'(done_b), 32'd0);
    check_eq("b_idle", 32'(busy_b), 32'd0);

    // Back-to-back passes, second started the cycle after done.
    pass_a(0, 1'b0, 1'b0);
    pass_a(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
